counter_ud_prog: RTL and testbench

Parametrised up/down counter and successor to the basic 4-bit load/up/down counter. Adds a programmable upper bound (modulus), a programmable step, and three run modes: wrap, saturate and one-shot. Also adds a registered terminal-count pulse and sticky overflow/underflow flags. Used as a generic timer/event counter in datapath and testbench-facing blocks, with all state on one clock domain.

---
 rtl/counter_prog_pkg.sv | 22 ++
 rtl/counter_prog_next.sv | 116 +++++++++++
 rtl/counter_ud_prog.sv | 147 ++++++++++++++
 tb/tb_counter_ud_prog.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_prog_pkg.sv
// ---------------------------------------------------------------------------
// counter_prog_pkg
// Shared types for the programmable up/down counter.
//   mode_e     : run mode selected by the 2-bit mode input
//   os_state_e : state of the one-shot launch FSM
// ---------------------------------------------------------------------------
package counter_prog_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      OS_IDLE = 2'd0,
      OS_RUN  = 2'd1,
      OS_DONE = 2'd2
   } os_state_e;

endpackage

// File: rtl/counter_prog_next.sv
// ---------------------------------------------------------------------------
// counter_prog_next
// Combinational next-count computation for one advancing edge.
//   count      in  : current count (assumed already within 0..limit)
//   s          in  : effective step, already clamped to limit+1 (WIDTH+1 bits)
//   limit      in  : upper bound of the count range
//   down       in  : 0 = count up, 1 = count down
//   mode       in  : run mode (reserved mode behaves as wrap)
//   next_count out : count after this step
//   hit_bound  out : a terminal-count pulse must be issued
//   ovf_evt    out : up-count went past limit (wrap/sat only)
//   unf_evt    out : down-count went below zero (wrap/sat only)
// ---------------------------------------------------------------------------
module counter_prog_next
   import counter_prog_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH:0]   s,
   input  logic [WIDTH-1:0] limit,
   input  logic             down,
   input  mode_e            mode,
   output logic [WIDTH-1:0] next_count,
   output logic             hit_bound,
   output logic             ovf_evt,
   output logic             unf_evt
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] lim_ext;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] wrap_up;
   logic [WIDTH:0] wrap_dn;

   // All intermediate math is one bit wider than the count so that
   // count+s and count+limit+1 cannot overflow.
   assign cnt_ext = {1'b0, count};
   assign lim_ext = {1'b0, limit};
   assign sum     = cnt_ext + s;
   assign wrap_up = sum - (lim_ext + ONE);
   assign wrap_dn = cnt_ext + lim_ext + ONE - s;

   always_comb begin
      next_count = count;
      hit_bound  = 1'b0;
      ovf_evt    = 1'b0;
      unf_evt    = 1'b0;
      // A zero step leaves the count alone and must not raise any event,
      // including the one-shot "already at bound" case.
      if (s != '0) begin
         if (!down) begin
            case (mode)
               MODE_SAT: begin
                  if (sum > lim_ext) begin
                     next_count = limit;
                     hit_bound  = (count != limit);
                     ovf_evt    = 1'b1;
                  end else begin
                     next_count = sum[WIDTH-1:0];
                  end
               end
               MODE_ONESHOT: begin
                  if (sum >= lim_ext) begin
                     next_count = limit;
                     hit_bound  = 1'b1;
                  end else begin
                     next_count = sum[WIDTH-1:0];
                  end
               end
               default: begin
                  if (sum > lim_ext) begin
                     next_count = wrap_up[WIDTH-1:0];
                     hit_bound  = 1'b1;
                     ovf_evt    = 1'b1;
                  end else begin
                     next_count = sum[WIDTH-1:0];
                  end
               end
            endcase
         end else begin
            case (mode)
               MODE_SAT: begin
                  if (s > cnt_ext) begin
                     next_count = '0;
                     hit_bound  = (count != '0);
                     unf_evt    = 1'b1;
                  end else begin
                     next_count = count - s[WIDTH-1:0];
                  end
               end
               MODE_ONESHOT: begin
                  if (s >= cnt_ext) begin
                     next_count = '0;
                     hit_bound  = 1'b1;
                  end else begin
                     next_count = count - s[WIDTH-1:0];
                  end
               end
               default: begin
                  if (s > cnt_ext) begin
                     next_count = wrap_dn[WIDTH-1:0];
                     hit_bound  = 1'b1;
                     unf_evt    = 1'b1;
                  end else begin
                     next_count = count - s[WIDTH-1:0];
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/counter_ud_prog.sv
// ---------------------------------------------------------------------------
// counter_ud_prog
// Programmable up/down counter with modulus, step and wrap/sat/one-shot modes.
//   clk, rstn  : clock, asynchronous active-low reset
//   en         : count enable
//   load_en    : load load_val (clamped to limit), highest priority
//   load_val   : load value
//   down       : 0 = up, 1 = down
//   step       : step magnitude (clamped to limit+1)
//   limit      : upper bound, count range is 0..limit
//   mode       : 0 wrap, 1 saturate, 2 one-shot, 3 behaves as wrap
//   start      : one-shot launch
//   clr_flags  : clear sticky ovf/unf (a same-cycle event wins)
//   count      : registered count
//   tc         : registered one-cycle terminal-count pulse
//   ovf, unf   : sticky overflow / underflow flags
//   busy       : one-shot FSM is running
//   at_bound   : count sits at the bound in the current direction
// ---------------------------------------------------------------------------
module counter_ud_prog
   import counter_prog_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              load_en,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              down,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic [1:0]        mode,
   input  logic              start,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              unf,
   output logic              busy,
   output logic              at_bound
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [1:0]       mode_q, mode_d;
   os_state_e        state_q, state_d;

   mode_e            mode_c;
   logic [WIDTH:0]   step_ext;
   logic [WIDTH:0]   lim_p1;
   logic [WIDTH:0]   s_eff;
   logic             advancing;
   logic [WIDTH-1:0] nxt_count;
   logic             hit_bound;
   logic             ovf_evt;
   logic             unf_evt;

   assign mode_c   = mode_e'(mode);
   assign step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step};
   assign lim_p1   = {1'b0, limit} + ONE;
   assign s_eff    = (step_ext > lim_p1) ? lim_p1 : step_ext;

   // One-shot mode only counts while its FSM is running.
   assign advancing = en && ((mode_c != MODE_ONESHOT) || (state_q == OS_RUN));

   counter_prog_next #(.WIDTH(WIDTH)) u_next (
      .count      (count_q),
      .s          (s_eff),
      .limit      (limit),
      .down       (down),
      .mode       (mode_c),
      .next_count (nxt_count),
      .hit_bound  (hit_bound),
      .ovf_evt    (ovf_evt),
      .unf_evt    (unf_evt)
   );

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q & ~clr_flags;
      unf_d   = unf_q & ~clr_flags;
      if (load_en) begin
         count_d = (load_val > limit) ? limit : load_val;
      end else if (count_q > limit) begin
         // limit was lowered below the current count
         count_d = limit;
      end else if (advancing) begin
         count_d = nxt_count;
         tc_d    = hit_bound;
         if (ovf_evt) ovf_d = 1'b1;
         if (unf_evt) unf_d = 1'b1;
      end
   end

   always_comb begin
      mode_d  = mode;
      state_d = state_q;
      if (mode != mode_q) begin
         state_d = OS_IDLE;
      end else if (mode_c == MODE_ONESHOT) begin
         case (state_q)
            OS_IDLE: if (start) state_d = OS_RUN;
            OS_RUN: begin
               // Only a real counting step can finish the run; load and
               // limit-clamp edges keep it running.
               if (!load_en && (count_q <= limit) && advancing && hit_bound)
                  state_d = OS_DONE;
            end
            OS_DONE: if (start) state_d = OS_RUN;
            default: state_d = OS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         mode_q  <= 2'd0;
         state_q <= OS_IDLE;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         mode_q  <= mode_d;
         state_q <= state_d;
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;
   assign busy     = (state_q == OS_RUN);
   assign at_bound = (!down && (count_q == limit)) || (down && (count_q == '0));

endmodule

// File: tb/tb_counter_ud_prog.sv
// ---------------------------------------------------------------------------
// tb_counter_ud_prog
// Self-checking bench: directed scenarios with literal expectations, then
// randomized stimulus, all compared every cycle against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_counter_ud_prog;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en, load_en, down, start, clr_flags;
   logic [7:0] load_val, limit;
   logic [3:0] step;
   logic [1:0] mode;
   logic [7:0] count;
   logic       tc, ovf, unf, busy, at_bound;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // behavioural model state
   int m_count, m_tc, m_ovf, m_unf, m_st, m_prev_mode;

   counter_ud_prog #(.WIDTH(8), .STEP_W(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .load_en   (load_en),
      .load_val  (load_val),
      .down      (down),
      .step      (step),
      .limit     (limit),
      .mode      (mode),
      .start     (start),
      .clr_flags (clr_flags),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf),
      .unf       (unf),
      .busy      (busy),
      .at_bound  (at_bound)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
   endtask

   task automatic model_reset();
      m_count = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_st = 0; m_prev_mode = 0;
   endtask

   // One clock edge of the counter, expressed with plain integer arithmetic.
   // m_st: 0 idle, 1 running, 2 done.
   task automatic model_step();
      int L, c, s, md, tcv, eo, eu, bnd;
      bit adv;
      if (!rstn) begin
         model_reset();
         return;
      end
      L = int'(limit); c = m_count; s = int'(step);
      if (s > L + 1) s = L + 1;
      md  = (mode == 2'd3) ? 0 : int'(mode);
      adv = en && (md != 2 || m_st == 1);
      tcv = 0; eo = 0; eu = 0; bnd = 0;
      if (load_en) c = (int'(load_val) > L) ? L : int'(load_val);
      else if (c > L) c = L;
      else if (adv && s > 0) begin
         if (!down) begin
            case (md)
               0: begin if (c + s > L) begin tcv = 1; eo = 1; end c = (c + s) % (L + 1); end
               1: begin if (c + s > L) begin tcv = (c != L); eo = 1; c = L; end else c = c + s; end
               default: begin if (c + s >= L) begin tcv = 1; bnd = 1; c = L; end else c = c + s; end
            endcase
         end else begin
            case (md)
               0: begin if (s > c) begin tcv = 1; eu = 1; end c = (c - s + L + 1) % (L + 1); end
               1: begin if (s > c) begin tcv = (c != 0); eu = 1; c = 0; end else c = c - s; end
               default: begin if (s >= c) begin tcv = 1; bnd = 1; c = 0; end else c = c - s; end
            endcase
         end
      end
      if (int'(mode) != m_prev_mode) m_st = 0;
      else if (mode == 2'd2) begin
         if ((m_st == 0 || m_st == 2) && start) m_st = 1;
         else if (m_st == 1 && bnd != 0) m_st = 2;
      end
      m_ovf = eo ? 1 : (clr_flags ? 0 : m_ovf);
      m_unf = eu ? 1 : (clr_flags ? 0 : m_unf);
      m_prev_mode = int'(mode);
      m_tc = tcv;
      m_count = c;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #2;
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("count", int'(count), m_count);
            check("tc", int'(tc), m_tc);
            check("ovf", int'(ovf), m_ovf);
            check("unf", int'(unf), m_unf);
            check("busy", int'(busy), (m_st == 1) ? 1 : 0);
            check("at_bound", int'(at_bound),
                  ((!down && m_count == int'(limit)) || (down && m_count == 0)) ? 1 : 0);
         end
      end
   end

   initial begin
      rstn = 1'b0; en = 0; load_en = 0; load_val = 0; down = 0; start = 0;
      clr_flags = 0; step = 0; limit = 8'd9; mode = 2'd0;
      model_reset();
      cyc();
      chk_en = 1'b1;
      check("rst_count", int'(count), 0);
      check("rst_tc", int'(tc), 0);
      check("rst_busy", int'(busy), 0);
      cyc();
      rstn = 1'b1;

      // WRAP up: limit 9, step 3
      step = 4'd3; load_en = 1; load_val = 8'd0;
      cyc(); check("wu_load", int'(count), 0);
      load_en = 0; en = 1;
      cyc(); check("wu_3", int'(count), 3);
      cyc(); check("wu_6", int'(count), 6);
      cyc(); check("wu_9", int'(count), 9); check("wu_9_tc", int'(tc), 0);
      cyc(); check("wu_2", int'(count), 2); check("wu_2_tc", int'(tc), 1);
      check("wu_ovf", int'(ovf), 1);
      cyc(); check("wu_5", int'(count), 5); check("wu_5_tc", int'(tc), 0);
      en = 0; clr_flags = 1;
      cyc(); check("clr_ovf", int'(ovf), 0);
      clr_flags = 0;

      // WRAP down: limit 9, step 4, from 2
      step = 4'd4; down = 1; load_en = 1; load_val = 8'd2;
      cyc(); check("wd_load", int'(count), 2);
      load_en = 0; en = 1;
      cyc(); check("wd_8", int'(count), 8); check("wd_tc", int'(tc), 1);
      check("wd_unf", int'(unf), 1);
      cyc(); check("wd_4", int'(count), 4); check("wd_4_tc", int'(tc), 0);
      cyc(); check("wd_0", int'(count), 0);

      // WRAP with step = limit+1: count holds, tc every cycle
      down = 0; en = 0; limit = 8'd5; step = 4'd6; load_en = 1; load_val = 8'd3;
      cyc();
      load_en = 0; en = 1;
      cyc(); check("wfull_cnt", int'(count), 3); check("wfull_tc1", int'(tc), 1);
      cyc(); check("wfull_tc2", int'(tc), 1);

      // SAT up: limit 200, step 15, from 190
      en = 0; mode = 2'd1; limit = 8'd200; step = 4'd15; load_en = 1;
      load_val = 8'd190; clr_flags = 1;
      cyc(); check("sat_load", int'(count), 190); check("sat_clr", int'(ovf), 0);
      load_en = 0; clr_flags = 0; en = 1;
      cyc(); check("sat_200", int'(count), 200); check("sat_tc", int'(tc), 1);
      check("sat_ovf", int'(ovf), 1);
      cyc(); check("sat_hold", int'(count), 200); check("sat_tc2", int'(tc), 0);
      clr_flags = 1;
      cyc(); check("sat_setwins", int'(ovf), 1);
      clr_flags = 0;

      // ONESHOT: limit 10, step 4
      en = 0; mode = 2'd2; limit = 8'd10; step = 4'd4; load_en = 1; load_val = 8'd0;
      cyc(); check("os_idle", int'(busy), 0);
      load_en = 0; start = 1; en = 1;
      cyc(); check("os_busy", int'(busy), 1); check("os_c0", int'(count), 0);
      start = 0;
      cyc(); check("os_4", int'(count), 4);
      cyc(); check("os_8", int'(count), 8);
      cyc(); check("os_10", int'(count), 10); check("os_tc", int'(tc), 1);
      check("os_done", int'(busy), 0);
      cyc(); check("os_hold", int'(count), 10); check("os_tc2", int'(tc), 0);

      // limit lowered below count, and load clamp
      en = 0; mode = 2'd0; limit = 8'd60; load_en = 1; load_val = 8'd50;
      cyc(); check("cl_load", int'(count), 50);
      load_en = 0; limit = 8'd20;
      cyc(); check("cl_lim", int'(count), 20); check("cl_tc", int'(tc), 0);
      load_en = 1; load_val = 8'd255;
      cyc(); check("cl_ld255", int'(count), 20);
      load_en = 0;

      // async reset in the middle of a one-shot run
      mode = 2'd2; limit = 8'd100; step = 4'd1; load_en = 1; load_val = 8'd0;
      cyc();
      load_en = 0; start = 1; en = 1;
      cyc();
      start = 0;
      cyc(); cyc(); cyc();
      check("ar_pre_cnt", int'(count), 3); check("ar_pre_busy", int'(busy), 1);
      check("ar_pre_ovf", int'(ovf), 1);
      rstn = 1'b0; model_reset();
      #1;
      check("ar_cnt", int'(count), 0); check("ar_busy", int'(busy), 0);
      check("ar_ovf", int'(ovf), 0); check("ar_unf", int'(unf), 0);
      cyc();
      rstn = 1'b1;
      cyc(); check("ar_nostart", int'(busy), 0); check("ar_nocnt", int'(count), 0);
      start = 1;
      cyc(); check("ar_start", int'(busy), 1);
      start = 0;
      cyc(); check("ar_run", int'(count), 1);

      // randomized stimulus
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(3) != 0);
         load_en   = ($urandom_range(9) == 0);
         load_val  = 8'($urandom_range(255));
         start     = ($urandom_range(7) == 0);
         clr_flags = ($urandom_range(9) == 0);
         step      = 4'($urandom_range(15));
         if ($urandom_range(9) == 0) down = ~down;
         if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(39) == 0) limit = 8'($urandom_range(255));
         if ($urandom_range(199) == 0) begin
            rstn = 1'b0; model_reset();
         end else begin
            rstn = 1'b1;
         end
         cyc();
      end
      rstn = 1'b1;
      cyc();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
